// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider and tick generator.
// New divisors are staged per channel and only take effect at that channel's period wrap.
module clk_div_multi #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_sel,
    input  logic [WIDTH-1:0]            wr_div,
    input  logic [CHANNELS-1:0]         ch_en,
    input  logic                        sync,
    output logic [CHANNELS-1:0]         clk_out,
    output logic [CHANNELS-1:0]         tick,
    output logic [CHANNELS-1:0]         pending
);

    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [WIDTH-1:0]    cnt_q      [CHANNELS];
    logic [WIDTH-1:0]    cnt_d      [CHANNELS];
    logic [WIDTH-1:0]    div_cur_q  [CHANNELS];
    logic [WIDTH-1:0]    div_cur_d  [CHANNELS];
    logic [WIDTH-1:0]    div_pend_q [CHANNELS];
    logic [WIDTH-1:0]    div_pend_d [CHANNELS];
    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] pend_d;
    logic [CHANNELS-1:0] clk_out_d;
    logic [CHANNELS-1:0] tick_d;
    logic                sel_ok_c;

    // Out-of-range channel indices only exist when CHANNELS is not a power of two.
    if ((2 ** SEL_W) == CHANNELS) begin : g_sel_full
        assign sel_ok_c = 1'b1;
    end else begin : g_sel_part
        assign sel_ok_c = (32'(wr_sel) < CHANNELS);
    end

    // Per-channel next state: halt/sync/wrap all restart the period and absorb a staged divisor.
    always_comb begin
        logic halted;
        logic wrap;
        logic restart;
        halted     = 1'b0;
        wrap       = 1'b0;
        restart    = 1'b0;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        clk_out_d  = '0;
        tick_d     = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            halted  = !ch_en[i] || (div_cur_q[i] == '0);
            wrap    = (cnt_q[i] == (div_cur_q[i] - WIDTH'(1)));
            restart = halted || sync || wrap;

            if (restart) begin
                cnt_d[i] = '0;
                if (pend_q[i]) begin
                    div_cur_d[i] = div_pend_q[i];
                    pend_d[i]    = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end

            // A wrap into divisor 0 halts the channel, so it must not emit a final tick.
            tick_d[i]    = !halted && !sync && wrap && (div_cur_d[i] != '0);
            clk_out_d[i] = !halted && (div_cur_d[i] != '0) &&
                           (cnt_d[i] >= (div_cur_d[i] >> 1));

            // Write lands after the boundary decision so a same-edge write waits for the next wrap.
            if (wr_en && sel_ok_c && (wr_sel == SEL_W'(i))) begin
                div_pend_d[i] = wr_div;
                pend_d[i]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i]      <= '0;
                div_cur_q[i]  <= WIDTH'(DEFAULT_DIV);
                div_pend_q[i] <= '0;
            end
            pend_q  <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            clk_out    <= clk_out_d;
            tick       <= tick_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed vector table, corner sequences and random traffic vs a period model.
module tb_clk_div_multi;

    localparam int unsigned C     = 5;
    localparam int unsigned W     = 28;
    localparam int unsigned SEL_W = $clog2(C);

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [W-1:0]     wr_div;
    logic [C-1:0]     ch_en;
    logic             sync;
    logic [C-1:0]     clk_out;
    logic [C-1:0]     tick;
    logic [C-1:0]     pending;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_multi #(.CHANNELS(C), .WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_div  (wr_div),
        .ch_en   (ch_en),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // Reference: each channel tracks its position within the current period and a staged divisor.
    int           m_pos  [C];
    int           m_div  [C];
    int           m_pval [C];
    bit           m_pend [C];
    logic [C-1:0] m_clk;
    logic [C-1:0] m_tick;
    logic [C-1:0] m_pnd;

    function automatic void model_reset();
        for (int i = 0; i < C; i++) begin
            m_pos[i] = 0; m_div[i] = 2; m_pval[i] = 0; m_pend[i] = 0;
        end
        m_clk = '0; m_tick = '0; m_pnd = '0;
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < C; i++) begin
            bit run;
            bit wrapped;
            run     = ch_en[i] && (m_div[i] != 0);
            wrapped = run && !sync && (m_pos[i] == m_div[i] - 1);
            if (!run || sync || wrapped) begin
                m_pos[i] = 0;
                if (m_pend[i]) begin
                    m_div[i]  = m_pval[i];
                    m_pend[i] = 0;
                end
            end else begin
                m_pos[i] = m_pos[i] + 1;
            end
            m_tick[i] = wrapped && (m_div[i] > 0);
            m_clk[i]  = run && (m_div[i] > 0) && (m_pos[i] >= m_div[i] / 2);
            if (wr_en && (int'(wr_sel) == i)) begin
                m_pval[i] = int'(wr_div);
                m_pend[i] = 1;
            end
            m_pnd[i] = m_pend[i];
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the same edge, strobes drop, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        wr_en = 1'b0;
        sync  = 1'b0;
        chk("model_clk_out", 32'(clk_out), 32'(m_clk));
        chk("model_tick",    32'(tick),    32'(m_tick));
        chk("model_pending", 32'(pending), 32'(m_pnd));
    endtask

    task automatic write(input int sel, input int div);
        wr_en  = 1'b1;
        wr_sel = SEL_W'(sel);
        wr_div = W'(div);
        step();
    endtask

    task automatic wait_clear(input int ch);
        int n;
        n = 0;
        while (pending[ch] && n < 16) begin
            step();
            n++;
        end
        chk("pending_timeout", 32'(pending[ch]), 32'd0);
    endtask

    typedef struct {
        bit         wr_en;
        int         sel;
        int         div;
        logic [4:0] clk;
        logic [4:0] tick;
        logic [4:0] pend;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n;
        tbl[0] = '{1'b0, 0, 0, 5'h1F, 5'h00, 5'h00};
        tbl[1] = '{1'b1, 1, 5, 5'h00, 5'h1F, 5'h02};
        tbl[2] = '{1'b0, 0, 0, 5'h1F, 5'h00, 5'h02};
        tbl[3] = '{1'b0, 0, 0, 5'h00, 5'h1F, 5'h00};
        tbl[4] = '{1'b0, 0, 0, 5'h1D, 5'h00, 5'h00};
        tbl[5] = '{1'b0, 0, 0, 5'h02, 5'h1D, 5'h00};
        tbl[6] = '{1'b0, 0, 0, 5'h1F, 5'h00, 5'h00};
        tbl[7] = '{1'b0, 0, 0, 5'h02, 5'h1D, 5'h00};
        tbl[8] = '{1'b0, 0, 0, 5'h1D, 5'h02, 5'h00};

        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_div = '0; sync = 1'b0; ch_en = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_clk_out", 32'(clk_out), 32'd0);
        chk("reset_tick",    32'(tick),    32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        rst = 1'b0;

        // Default divide-by-2 start-up, then ch1 retimed to 5.
        for (int i = 0; i < 9; i++) begin
            wr_en  = tbl[i].wr_en;
            wr_sel = SEL_W'(tbl[i].sel);
            wr_div = W'(tbl[i].div);
            step();
            chk($sformatf("vec%0d_clk_out", i), 32'(clk_out), 32'(tbl[i].clk));
            chk($sformatf("vec%0d_tick", i),    32'(tick),    32'(tbl[i].tick));
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
        end

        // Divide-by-1, then 0 (halt), then 3 applied from the halted state.
        write(2, 1);
        wait_clear(2);
        repeat (3) begin
            step();
            chk("div1_clk", 32'(clk_out[2]), 32'd1);
            chk("div1_tick", 32'(tick[2]), 32'd1);
        end
        write(2, 0);
        wait_clear(2);
        chk("div0_clk", 32'(clk_out[2]), 32'd0);
        chk("div0_tick", 32'(tick[2]), 32'd0);
        step();
        chk("div0_hold", 32'(clk_out[2]), 32'd0);
        write(2, 3);
        chk("div3_pend_set", 32'(pending[2]), 32'd1);
        step();
        chk("div3_pend_clr", 32'(pending[2]), 32'd0);
        repeat (3) step();
        chk("div3_first_tick", 32'(tick[2]), 32'd1);

        // Phase sync: ticks of divide-by-4 and divide-by-6 coincide every 12 cycles.
        write(0, 4);
        write(1, 6);
        wait_clear(0);
        wait_clear(1);
        repeat (3) step();
        sync = 1'b1;
        step();
        chk("sync_clk", 32'(clk_out[1:0]), 32'd0);
        chk("sync_tick", 32'(tick[1:0]), 32'd0);
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k % 12 == 0) chk("sync_coincide", 32'(tick[1:0]), 32'd3);
        end

        // Disabled channel absorbs a write on the next edge; re-enable ticks after 7 cycles.
        ch_en[3] = 1'b0;
        step();
        write(3, 7);
        chk("dis_pend_set", 32'(pending[3]), 32'd1);
        step();
        chk("dis_pend_clr", 32'(pending[3]), 32'd0);
        chk("dis_clk", 32'(clk_out[3]), 32'd0);
        ch_en[3] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[3] && n < 20);
        chk("en_first_tick", 32'(n), 32'd7);

        // Out-of-range channel indices are ignored.
        wait_clear(0);
        write(5, 9);
        chk("oob5_pending", 32'(pending), 32'd0);
        write(7, 3);
        chk("oob7_pending", 32'(pending), 32'd0);

        // Asynchronous reset between edges with a divisor pending.
        write(3, 5);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_clk_out", 32'(clk_out), 32'd0);
        chk("arst_tick",    32'(tick),    32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        repeat (4) step();
        chk("arst_default_clk", 32'(clk_out), 32'h00);
        chk("arst_default_tick", 32'(tick), 32'h1F);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_en  = ($urandom_range(0, 2) == 0);
            wr_sel = SEL_W'($urandom_range(0, 7));
            wr_div = W'($urandom_range(0, 7));
            sync   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) ch_en = C'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised multi-channel clock divider and tick generator. It succeeds the fixed single-divisor divider used beside the PLL in the top level. Each channel has a runtime-writable divisor that is applied glitch-free at its period boundary, a per-channel enable, a global phase-sync and registered outputs. It sits on the CPU master clock and feeds timers, UART baud logic and LED blink logic.

Parameters:
CHANNELS, 4, number of independent divider channels; must be at least 2.
WIDTH, 28, divisor and counter width in bits.
DEFAULT_DIV, 2, divisor loaded into every channel at reset; must be at least 2.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, asynchronous, active-high.
wr_en  in  1  divisor write strobe, one cycle per write.
wr_sel  in  $clog2(CHANNELS)  channel index for the write.
wr_div  in  WIDTH  new divisor value, unsigned.
ch_en  in  CHANNELS  per-channel run enable.
sync  in  1  restarts the phase of all channels simultaneously.
clk_out  out  CHANNELS  divided square wave per channel, registered.
tick  out  CHANNELS  one-cycle pulse at the start of each period, registered.
pending  out  CHANNELS  high while a written divisor waits for its boundary.

Behaviour:
- Per-channel state: cnt[WIDTH], div_cur[WIDTH], div_pend[WIDTH], pend flag.
- Reset (async, immediate): cnt=0, div_cur=DEFAULT_DIV, div_pend=0, pend=0, clk_out=0, tick=0, pending=0.
- Write: if wr_en and wr_sel<CHANNELS, then div_pend[wr_sel]<=wr_div and pend<=1 on that edge. If wr_sel>=CHANNELS, the write is ignored.
- Repeated writes before a boundary: the last write wins. pending stays high.
- Same-edge write and boundary: the boundary uses the pend/div_pend state from before the edge. The new value becomes pending and applies at the next boundary.
- Running channel (ch_en=1, div_cur>=1, sync=0):
  - If cnt==div_cur-1 (wrap): cnt<=0, tick<=1. If pend: div_cur<=div_pend, pend<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
- clk_out is registered: clk_out<=(cnt_next >= (div_next>>1)), using the next-state count and divisor.
  - Even D: low D/2 cycles, then high D/2 cycles.
  - Odd D: low floor(D/2) cycles, then high ceil(D/2) cycles.
  - D=1: clk_out constantly 1 and tick every cycle.
  - The tick cycle is the first cycle of the low phase for D>=2.
- Halted channel (ch_en=0 or div_cur==0): cnt<=0, clk_out<=0, tick<=0. Any pend is applied on the next edge.
- Enable rising: counting starts from cnt=0. The first tick occurs D cycles after the first enabled edge. No tick on the enable edge itself.
- sync (priority over counting, all channels):
  - cnt<=0, tick<=0, pend applied.
  - clk_out per the formula, so 1 only when D=1.
  - Disabled channels remain halted.
- Period boundary for a divisor change is the wrap edge only. Duty and period never mix old and new values within one period.
- Arithmetic is unsigned WIDTH-bit; the counter never exceeds div_cur-1.
- Latency: write to pending=1 is 1 edge. pending=1 to the new period is at most old D edges.

Test Plan:
- Reset release, all ch_en=1, DEFAULT_DIV=2 -> every clk_out 0,1,0,1...; tick high on cycles 2,4,6... after release; pending=0.
- Write ch1 wr_div=5 while cnt[1]=0 -> pending[1]=1 for 2 cycles. After the wrap, clk_out[1] is low 2 / high 3, tick[1] every 5 cycles and pending[1]=0. Channels 0,2,3 are unaffected.
- Write ch2 div=1 -> clk_out[2]=1 constantly and tick[2] every cycle. Then write div=0 -> outputs 0 from the boundary edge. Write div=3 while at 0 -> pending clears after 1 edge and period 3 starts.
- ch0 div=4, ch1 div=6 at arbitrary phases, pulse sync -> both cnt=0. Ticks coincide 12 cycles after sync and every 12 thereafter.
- Assert rst between clock edges mid-period with pending set -> clk_out/tick/pending go to 0 without a clock edge. After release, all channels run at DEFAULT_DIV.
- ch_en[3]=0, write div=7 -> pending[3] clears the next edge with clk_out[3]=0. Re-enable -> first tick[3] 7 cycles later. Write wr_sel=CHANNELS (CHANNELS non-power-of-2 build) -> no state change.
